// File: rtl/gcd_pkg.sv
// Shared types and constants for the handshaked GCD engine.
// Build option: GCD_STEIN_EN selects the binary (Stein) iteration instead of subtraction.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } gcd_state_t;

    localparam int GCD_WIDTH_DEF = 11;

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD iteration. The FSM in gcd_hs only sequences this block.
// Build option: GCD_STEIN_EN selects binary (Stein) steps with a shared power-of-two
// counter k; otherwise one subtraction per step and no k.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH_DEF
`ifdef GCD_STEIN_EN
    ,
    parameter int KW    = $clog2(WIDTH)
`endif
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
`ifdef GCD_STEIN_EN
    input  logic [KW-1:0]    k_i,
    output logic [KW-1:0]    k_o,
`endif
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             eq_o
);

`ifdef GCD_STEIN_EN
    // Binary step: strip common twos into k, strip lone twos, halve the odd difference.
    always_comb begin
        a_o  = a_i;
        b_o  = b_i;
        k_o  = k_i;
        eq_o = (a_i == b_i);
        if (!eq_o) begin
            unique case ({a_i[0], b_i[0]})
                2'b00: begin
                    a_o = a_i >> 1;
                    b_o = b_i >> 1;
                    k_o = k_i + KW'(1);
                end
                2'b01:   a_o = a_i >> 1;
                2'b10:   b_o = b_i >> 1;
                default: begin
                    // both odd: difference is even, so halving it is exact
                    if (a_i > b_i) a_o = (a_i - b_i) >> 1;
                    else           b_o = (b_i - a_i) >> 1;
                end
            endcase
        end
    end
`else
    // Subtractive step: the compare guards the subtraction against underflow.
    always_comb begin
        a_o  = a_i;
        b_o  = b_i;
        eq_o = (a_i == b_i);
        if (a_i > b_i)      a_o = a_i - b_i;
        else if (a_i < b_i) b_o = b_i - a_i;
    end
`endif

endmodule

// File: rtl/gcd_hs.sv
// GCD engine with valid/ready handshakes: accepts one operand pair in IDLE,
// iterates in CALC, holds the result in DONE until the consumer takes it.
// Build option: GCD_STEIN_EN (binary iteration; adds the k register).
module gcd_hs
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_o,
    output logic             err_o
);

    gcd_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] step_a, step_b;
    logic             step_eq;
    logic [WIDTH-1:0] result;

`ifdef GCD_STEIN_EN
    localparam int KW = $clog2(WIDTH);
    logic [KW-1:0] k_q, k_d, step_k;

    gcd_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
        .a_i (a_q),
        .b_i (b_q),
        .k_i (k_q),
        .k_o (step_k),
        .a_o (step_a),
        .b_o (step_b),
        .eq_o(step_eq)
    );

    // Common factor of two stripped during iteration is restored at the end.
    assign result = a_q << k_q;
`else
    gcd_step #(.WIDTH(WIDTH)) u_step (
        .a_i (a_q),
        .b_i (b_q),
        .a_o (step_a),
        .b_o (step_b),
        .eq_o(step_eq)
    );

    assign result = a_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign data_o    = data_q;
    assign err_o     = err_q;

    // Next state and datapath: zero operands short-circuit straight to DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef GCD_STEIN_EN
        k_d     = k_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef GCD_STEIN_EN
                    k_d = '0;
`endif
                    if (x_i == '0 && y_i == '0) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (x_i == '0) begin
                        data_d  = y_i;
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else if (y_i == '0) begin
                        data_d  = x_i;
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        a_d     = x_i;
                        b_d     = y_i;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (step_eq) begin
                    data_d  = result;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    a_d = step_a;
                    b_d = step_b;
`ifdef GCD_STEIN_EN
                    k_d = step_k;
`endif
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Operand, result and error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
`ifdef GCD_STEIN_EN
            k_q    <= '0;
`endif
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            data_q <= data_d;
            err_q  <= err_d;
`ifdef GCD_STEIN_EN
            k_q    <= k_d;
`endif
        end
    end

endmodule

// File: tb/tb_gcd_hs.sv
// Directed bench for gcd_hs (WIDTH=11) plus an exhaustive WIDTH=6 instance.
// Expected results come from a Euclid-modulo model via scoreboard queues.
module tb_gcd_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, err;
    logic [10:0] x, y, data;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_err;
    logic [5:0]  s_x, s_y, s_data;

    int checks = 0;
    int fails  = 0;
    int unsigned sb[$];
    int unsigned sq[$];
    int lat;

    localparam int LIM = 4200;

    always #5 clk = ~clk;

    gcd_hs #(.WIDTH(11)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_i(x), .y_i(y), .out_valid(out_valid), .out_ready(out_ready),
        .data_o(data), .err_o(err)
    );

    gcd_hs #(.WIDTH(6)) dut6 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .x_i(s_x), .y_i(s_y), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .data_o(s_data), .err_o(s_err)
    );

    function automatic int unsigned mgcd(input int unsigned a0, input int unsigned b0);
        int unsigned a, b, t;
        a = a0;
        b = b0;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // expected packed as {err, data}
    function automatic int unsigned mexp(input int unsigned a, input int unsigned b);
        return ((a == 0 && b == 0) ? 32'h1_0000 : 32'h0) | mgcd(a, b);
    endfunction

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present a pair for one accept edge; push the model result at acceptance.
    task automatic send(input int unsigned xv, input int unsigned yv);
        @(negedge clk);
        x = 11'(xv);
        y = 11'(yv);
        in_valid = 1'b1;
        chk_b("in_ready_before_E0", in_ready, 1'b1);
        @(posedge clk);
        sb.push_back(mexp(xv, yv));
        @(negedge clk);
        in_valid = 1'b0;
        chk_b("in_ready_after_E0", in_ready, 1'b0);
    endtask

    // Count edges past E0 until out_valid; bounded.
    task automatic wait_res(output int l);
        l = 0;
        while (!out_valid && l < LIM) begin
            @(posedge clk);
            @(negedge clk);
            l++;
        end
        chk_b("result_timeout", out_valid, 1'b1);
    endtask

    task automatic pop_chk(input string tag);
        int unsigned e;
        if (sb.size() == 0) begin
            chk_i({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk_i({tag, "_data"}, int'(data), int'(e & 32'h7FF));
            chk_b({tag, "_err"}, err, e[16]);
        end
    endtask

    task automatic drain();
        @(posedge clk);
        @(negedge clk);
        chk_b("drain_out_valid", out_valid, 1'b0);
        chk_b("drain_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; x = '0; y = '0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_x = '0; s_y = '0; s_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_b("rst_in_ready", in_ready, 1'b1);
        chk_b("rst_out_valid", out_valid, 1'b0);
        chk_i("rst_data", int'(data), 0);
        chk_b("rst_err", err, 1'b0);
        rst = 1'b1;

        // basic subtractive pair: result after E3
        send(12, 18);
        wait_res(lat);
`ifndef GCD_STEIN_EN
        chk_i("t1_latency", lat, 3);
`endif
        pop_chk("t1");
        drain();

        // zero operands
        send(0, 0);
        wait_res(lat);
        chk_i("t2_zz_latency", lat, 0);
        pop_chk("t2_zz");
        drain();
        send(0, 35);
        wait_res(lat);
        chk_i("t2_z35_latency", lat, 0);
        pop_chk("t2_z35");
        drain();
        send(35, 0);
        wait_res(lat);
        pop_chk("t2_35z");
        drain();

        // backpressure, with in_valid noise that must be ignored
        out_ready = 1'b0;
        send(1071, 462);
        wait_res(lat);
        pop_chk("t3");
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; x = 11'd5; y = 11'd10;
            @(posedge clk);
            @(negedge clk);
            chk_i("t3_hold_data", int'(data), 21);
            chk_b("t3_hold_err", err, 1'b0);
            chk_b("t3_hold_valid", out_valid, 1'b1);
            chk_b("t3_hold_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_b("t3_release_valid", out_valid, 1'b0);
        chk_b("t3_release_in_ready", in_ready, 1'b1);
        chk_i("t3_release_data_kept", int'(data), 21);

        // asynchronous reset mid-CALC
        send(2047, 1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk_b("t4_async_out_valid", out_valid, 1'b0);
        chk_b("t4_async_in_ready", in_ready, 1'b1);
        chk_i("t4_async_data", int'(data), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        send(9, 9);
        wait_res(lat);
        chk_i("t4_eq_latency", lat, 1);
        pop_chk("t4_eq");
        drain();

        // worst-case operand pair and a Stein-friendly pair
        send(2047, 1);
        wait_res(lat);
`ifdef GCD_STEIN_EN
        chk_b("t6_worst_bound", lat <= 23, 1'b1);
`else
        chk_i("t6_worst_latency", lat, 2047);
`endif
        pop_chk("t6_worst");
        drain();
        send(48, 180);
        wait_res(lat);
`ifdef GCD_STEIN_EN
        chk_b("t6_stein_bound", lat <= 23, 1'b1);
`endif
        pop_chk("t6_48_180");
        drain();
        send(2047, 2047);
        wait_res(lat);
        chk_i("t6_max_eq_latency", lat, 1);
        pop_chk("t6_max_eq");
        drain();

        // exhaustive WIDTH=6
        for (int xi = 0; xi < 64; xi++) begin
            for (int yi = 0; yi < 64; yi++) begin
                int n;
                int unsigned e;
                @(negedge clk);
                s_x = 6'(xi);
                s_y = 6'(yi);
                s_in_valid = 1'b1;
                @(posedge clk);
                sq.push_back(mexp(xi, yi));
                @(negedge clk);
                s_in_valid = 1'b0;
                n = 0;
                while (!s_out_valid && n < 80) begin
                    @(posedge clk);
                    @(negedge clk);
                    n++;
                end
                e = sq.pop_front();
                chk_i($sformatf("exh_%0d_%0d", xi, yi),
                      int'({s_out_valid, s_err, s_data}),
                      int'({1'b1, e[16], e[5:0]}));
                @(posedge clk);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
